trap_ctrl: RTL and testbench
============================

# trap_ctrl

- Sequences machine-mode trap entry (exceptions, external interrupt) and `mret` return for the RV32I core.
- Owns the single CSR write port and the CSR read port of `csregfile` while busy. Passes executrol/ID CSR traffic through when idle.
- Stalls and flushes the pipeline and issues a PC redirect to `mtvec` or `mepc`.
- Keeps a shadow of `mstatus.MIE` so interrupt acceptance needs no CSR read in the idle state.

## Interface

Parameters:
- XLEN, 32, data width
- CSR_AW, 12, CSR address width
- ADDR_MSTATUS, 12'h300, mstatus address
- ADDR_MTVEC, 12'h305, mtvec address
- ADDR_MEPC, 12'h341, mepc address
- ADDR_MCAUSE, 12'h342, mcause address
- CSR_NONE, 12'h000, "no CSR access" code (mdisable)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- ex_csr_waddr  in  CSR_AW  CSR write address from executrol
- ex_csr_wdata  in  XLEN  CSR write data from executrol
- ex_csr_raddr  in  CSR_AW  CSR read address from id
- csr_waddr_o  out  CSR_AW  to csregfile write address
- csr_wdata_o  out  XLEN  to csregfile write data
- csr_raddr_o  out  CSR_AW  to csregfile read address
- csr_rdata_i  in  XLEN  from csregfile read data
- exc_req  in  1  synchronous exception on the instruction in ID
- exc_cause  in  4  exception code: 2 illegal, 3 ebreak, 11 ecall
- inst_pc  in  XLEN  PC of the instruction in ID
- irq  in  1  external interrupt, level-sensitive
- mret_req  in  1  instruction in ID is `mret`
- stall_o  out  1  hold IF/ID
- flush_o  out  1  one-cycle pulse, kill the instruction in ID
- redirect_o  out  1  one-cycle pulse, load redirect_pc
- redirect_pc  out  XLEN  redirect target

## Operation

**States:** IDLE, T_EPC, T_CAUSE, T_STAT, T_JUMP, M_STAT, M_WR, M_JUMP.

**Accept (IDLE only):**
- take_exc = exc_req
- take_irq = irq & mie_q & !exc_req
- take_mret = mret_req & !exc_req & !take_irq
- Priority is exception > interrupt > mret.
- On any take:
  - flush_o=1, stall_o=1
  - latch pc_q=inst_pc
  - latch cause_q: {0, 27'b0, exc_cause} for an exception, 32'h8000000B for an interrupt
  - next state is T_EPC (trap) or M_STAT (mret)

**IDLE pass-through:** csr_waddr_o=ex_csr_waddr, csr_wdata_o=ex_csr_wdata, csr_raddr_o=ex_csr_raddr. This includes the accept cycle, so an older instruction's CSR write completes.

**Busy states:** ex_* inputs are ignored. csr_waddr_o=CSR_NONE unless listed below.

**Trap entry:**
- T_EPC: write mepc=pc_q; raddr=mstatus; capture mstat_q=csr_rdata_i.
- T_CAUSE: write mcause=cause_q.
- T_STAT:
  - write mstatus = mstat_q with MPIE(bit7)=mstat_q[3], MIE(bit3)=0, MPP(12:11)=2'b11
  - raddr=mtvec; capture tvec_q; mie_q<=0
- T_JUMP: redirect_o=1, redirect_pc={tvec_q[31:2],2'b00} (direct mode only); next state IDLE.

**mret:**
- M_STAT: raddr=mstatus; capture mstat_q.
- M_WR:
  - write mstatus = mstat_q with MIE=mstat_q[7], MPIE=1, MPP=2'b11
  - raddr=mepc; capture epc_q; mie_q<=mstat_q[7]
- M_JUMP: redirect_o=1, redirect_pc=epc_q; next state IDLE.

**MIE shadow:**
- In IDLE, when ex_csr_waddr==ADDR_MSTATUS: mie_q<=ex_csr_wdata[3].
- Reset value 0.

**Boundary conditions:**
- Requests arriving while busy are not latched. Upstream is stalled and re-presents them.
- An irq held across a trap is re-evaluated only in IDLE against the updated mie_q.
- A same-cycle reads-own-write hazard never occurs: busy-state reads never target the address being written that cycle.
- Reset assertion at any time forces IDLE immediately. Any write not yet clocked is abandoned.

## Timing

- Reset values:
  - state=IDLE, mie_q=0
  - stall_o=0, flush_o=0, redirect_o=0, redirect_pc=0
  - CSR outputs in pass-through
- Trap: accept at cycle 0. CSR writes land at the end of cycles 1, 2 and 3. redirect_o in cycle 4. stall_o high for cycles 0–4, 5 cycles total.
- mret: accept at cycle 0. mstatus write at the end of cycle 2. redirect_o in cycle 3. stall_o high for cycles 0–3.
- flush_o is high only in cycle 0.
- redirect_pc holds its last value after a redirect. It is meaningful only while redirect_o=1.

## Test plan

- **ecall:** mstatus=0x8, mtvec=0x200, exc_req with cause 11, inst_pc=0x100 -> cycle 1 mepc<=0x100; cycle 2 mcause<=0xB; cycle 3 mstatus<=0x1880; cycle 4 redirect 0x200; stall 5 cycles; flush 1 cycle.
- **Masked irq:** irq=1 with mie_q=0 -> no accept. Executrol writes mstatus=0x8 -> next cycle accept; mcause<=0x8000000B.
- **mret:** mstatus=0x1880, mepc=0x104 -> cycle 2 mstatus<=0x1888; cycle 3 redirect 0x104; mie_q=1 afterwards.
- **Simultaneous exc_req (cause 2) and irq with MIE=1:** exception taken with mcause=0x2; irq is not taken after return to IDLE (MIE=0) until an mret.
- **mtvec=0x203:** redirect_pc=0x200.
- **Reset in T_CAUSE:** immediate IDLE; no mcause/mstatus write; no redirect; outputs at reset values; CSR pass-through resumes.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer for the RV32I core.
// Owns the csregfile ports while busy and passes executrol/ID CSR traffic through when idle.
module trap_ctrl #(
    parameter int                XLEN         = 32,
    parameter int                CSR_AW       = 12,
    parameter logic [CSR_AW-1:0] ADDR_MSTATUS = 12'h300,
    parameter logic [CSR_AW-1:0] ADDR_MTVEC   = 12'h305,
    parameter logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341,
    parameter logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342,
    parameter logic [CSR_AW-1:0] CSR_NONE     = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CSR_AW-1:0] ex_csr_waddr,
    input  logic [XLEN-1:0]   ex_csr_wdata,
    input  logic [CSR_AW-1:0] ex_csr_raddr,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic [CSR_AW-1:0] csr_raddr_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    input  logic              exc_req,
    input  logic [3:0]        exc_cause,
    input  logic [XLEN-1:0]   inst_pc,
    input  logic              irq,
    input  logic              mret_req,
    output logic              stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc
);

    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_STAT, T_JUMP, M_STAT, M_WR, M_JUMP
    } state_t;

    state_t          state, state_nxt;
    logic            mie_q;
    logic [XLEN-1:0] pc_q, cause_q, mstat_q;
    logic            take_exc, take_irq, take_mret, idle;

    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    assign idle      = (state == IDLE);
    assign take_exc  = exc_req;
    assign take_irq  = irq & mie_q & ~exc_req;
    assign take_mret = mret_req & ~exc_req & ~take_irq;

    always_comb begin
        state_nxt   = state;
        stall_o     = 1'b1;
        flush_o     = 1'b0;
        redirect_o  = 1'b0;
        csr_waddr_o = CSR_NONE;
        csr_wdata_o = '0;
        csr_raddr_o = CSR_NONE;
        case (state)
            IDLE: begin
                // Pass-through stays on in the accept cycle so an older CSR write still lands.
                stall_o     = 1'b0;
                csr_waddr_o = ex_csr_waddr;
                csr_wdata_o = ex_csr_wdata;
                csr_raddr_o = ex_csr_raddr;
                if (take_exc || take_irq) begin
                    stall_o   = 1'b1;
                    flush_o   = 1'b1;
                    state_nxt = T_EPC;
                end else if (take_mret) begin
                    stall_o   = 1'b1;
                    flush_o   = 1'b1;
                    state_nxt = M_STAT;
                end
            end
            T_EPC: begin
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = pc_q;
                csr_raddr_o = ADDR_MSTATUS;
                state_nxt   = T_CAUSE;
            end
            T_CAUSE: begin
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
                state_nxt   = T_STAT;
            end
            T_STAT: begin
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = trap_mstatus(mstat_q);
                csr_raddr_o = ADDR_MTVEC;
                state_nxt   = T_JUMP;
            end
            T_JUMP: begin
                redirect_o = 1'b1;
                state_nxt  = IDLE;
            end
            M_STAT: begin
                csr_raddr_o = ADDR_MSTATUS;
                state_nxt   = M_WR;
            end
            M_WR: begin
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mret_mstatus(mstat_q);
                csr_raddr_o = ADDR_MEPC;
                state_nxt   = M_JUMP;
            end
            M_JUMP: begin
                redirect_o = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                stall_o   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // redirect_pc doubles as the captured mtvec/mepc: it is loaded the cycle before the jump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mie_q       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (idle && ex_csr_waddr == ADDR_MSTATUS)
                mie_q <= ex_csr_wdata[3];
            if (state == T_STAT) begin
                mie_q       <= 1'b0;
                redirect_pc <= {csr_rdata_i[XLEN-1:2], 2'b00};
            end
            if (state == M_WR) begin
                mie_q       <= mstat_q[7];
                redirect_pc <= csr_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (idle && (take_exc || take_irq || take_mret)) begin
            pc_q    <= inst_pc;
            cause_q <= take_exc ? {{(XLEN-4){1'b0}}, exc_cause}
                                : {1'b1, {(XLEN-5){1'b0}}, 4'd11};
        end
        if (state == T_EPC || state == M_STAT)
            mstat_q <= csr_rdata_i;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a small csregfile model plus a scoreboard of expected CSR writes and redirects.
module tb_trap_ctrl;

    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ex_csr_waddr, ex_csr_raddr, csr_waddr_o, csr_raddr_o;
    logic [31:0] ex_csr_wdata, csr_wdata_o, csr_rdata_i, inst_pc, redirect_pc;
    logic        exc_req, irq, mret_req, stall_o, flush_o, redirect_o;
    logic [3:0]  exc_cause;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] csr_mem [0:4];

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata), .ex_csr_raddr(ex_csr_raddr),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .csr_raddr_o(csr_raddr_o),
        .csr_rdata_i(csr_rdata_i),
        .exc_req(exc_req), .exc_cause(exc_cause), .inst_pc(inst_pc),
        .irq(irq), .mret_req(mret_req),
        .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc(redirect_pc)
    );

    function automatic logic [2:0] idx(input logic [11:0] a);
        case (a)
            MSTATUS: return 3'd0;
            MTVEC:   return 3'd1;
            MEPC:    return 3'd2;
            MCAUSE:  return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    assign csr_rdata_i = csr_mem[idx(csr_raddr_o)];

    always @(posedge clk)
        if (csr_waddr_o != 12'h000) csr_mem[idx(csr_waddr_o)] <= csr_wdata_o;

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        exp_wr.push_back(wr_t'{a, d});
    endtask

    // Called at the negedge: pops the scoreboard against whatever the DUT emits, then ends the cycle.
    task automatic sb_step();
        wr_t e;
        logic [31:0] r;
        if (csr_waddr_o !== 12'h000) begin
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_bad++;
                $display("FAIL csr_wr: got %h<=%h, required no write", csr_waddr_o, csr_wdata_o);
            end else begin
                e = exp_wr.pop_front();
                if (csr_waddr_o !== e.a || csr_wdata_o !== e.d) begin
                    n_bad++;
                    $display("FAIL csr_wr: got %h<=%h, required %h<=%h", csr_waddr_o, csr_wdata_o, e.a, e.d);
                end
            end
        end
        if (redirect_o === 1'b1) begin
            n_cmp++;
            if (exp_rd.size() == 0) begin
                n_bad++;
                $display("FAIL redirect: got pc %h, required no redirect", redirect_pc);
            end else begin
                r = exp_rd.pop_front();
                if (redirect_pc !== r) begin
                    n_bad++;
                    $display("FAIL redirect: got pc %h, required %h", redirect_pc, r);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        ex_csr_waddr = a;
        ex_csr_wdata = d;
        push_wr(a, d);
        @(negedge clk);
        sb_step();
        ex_csr_waddr = 12'h000;
        ex_csr_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_csr_waddr = '0; ex_csr_wdata = '0; ex_csr_raddr = MTVEC;
        exc_req = 1'b0; exc_cause = '0; inst_pc = '0; irq = 1'b0; mret_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({stall_o, flush_o, redirect_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got st/fl/rd=%b%b%b, required 000", stall_o, flush_o, redirect_o);
        end
        n_cmp++;
        if (redirect_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_pc: got %h, required 00000000", redirect_pc);
        end
        n_cmp++;
        if (csr_raddr_o !== MTVEC || csr_waddr_o !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_pass: got ra=%h wa=%h, required ra=%h wa=000", csr_raddr_o, csr_waddr_o, MTVEC);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ex_csr_raddr = '0;
        irq = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (flush_o !== 1'b0 || stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mie: got fl/st=%b%b with irq, required 00", flush_o, stall_o);
        end
        sb_step();
        irq = 1'b0;
    endtask

    task automatic test_ecall();
        logic e_st, e_fl, e_rd;
        logic [11:0] e_wa;
        csr_write(MSTATUS, 32'h8);
        csr_write(MTVEC, 32'h200);
        inst_pc = 32'h100; exc_cause = 4'd11; exc_req = 1'b1;
        push_wr(MEPC, 32'h100); push_wr(MCAUSE, 32'hB); push_wr(MSTATUS, 32'h1880);
        exp_rd.push_back(32'h200);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e_st = (c <= 4); e_fl = (c == 0); e_rd = (c == 4);
            e_wa = (c == 1) ? MEPC : (c == 2) ? MCAUSE : (c == 3) ? MSTATUS : 12'h000;
            n_cmp++;
            if ({stall_o, flush_o, redirect_o, csr_waddr_o} !== {e_st, e_fl, e_rd, e_wa}) begin
                n_bad++;
                $display("FAIL ecall_c%0d: got st/fl/rd/wa=%b%b%b/%h, required %b%b%b/%h",
                         c, stall_o, flush_o, redirect_o, csr_waddr_o, e_st, e_fl, e_rd, e_wa);
            end
            sb_step();
            if (c == 0) exc_req = 1'b0;
        end
    endtask

    task automatic test_masked_irq();
        logic e_st, e_fl, e_rd;
        inst_pc = 32'h180; irq = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (flush_o !== 1'b0 || stall_o !== 1'b0) begin
                n_bad++;
                $display("FAIL masked_irq_c%0d: got fl/st=%b%b, required 00", c, flush_o, stall_o);
            end
            sb_step();
        end
        csr_write(MSTATUS, 32'h8);
        push_wr(MEPC, 32'h180); push_wr(MCAUSE, 32'h8000000B); push_wr(MSTATUS, 32'h1880);
        exp_rd.push_back(32'h200);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e_st = (c <= 4); e_fl = (c == 0); e_rd = (c == 4);
            n_cmp++;
            if ({stall_o, flush_o, redirect_o} !== {e_st, e_fl, e_rd}) begin
                n_bad++;
                $display("FAIL irq_c%0d: got st/fl/rd=%b%b%b, required %b%b%b",
                         c, stall_o, flush_o, redirect_o, e_st, e_fl, e_rd);
            end
            sb_step();
            if (c == 0) irq = 1'b0;
        end
    endtask

    task automatic test_mret();
        logic e_st, e_fl, e_rd;
        logic [11:0] e_wa, e_ra;
        csr_write(MEPC, 32'h104);
        csr_write(MSTATUS, 32'h1880);
        mret_req = 1'b1;
        push_wr(MSTATUS, 32'h1888);
        exp_rd.push_back(32'h104);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e_st = (c <= 3); e_fl = (c == 0); e_rd = (c == 3);
            e_wa = (c == 2) ? MSTATUS : 12'h000;
            e_ra = (c == 1) ? MSTATUS : (c == 2) ? MEPC : 12'h000;
            n_cmp++;
            if ({stall_o, flush_o, redirect_o, csr_waddr_o, csr_raddr_o} !== {e_st, e_fl, e_rd, e_wa, e_ra}) begin
                n_bad++;
                $display("FAIL mret_c%0d: got st/fl/rd/wa/ra=%b%b%b/%h/%h, required %b%b%b/%h/%h",
                         c, stall_o, flush_o, redirect_o, csr_waddr_o, csr_raddr_o, e_st, e_fl, e_rd, e_wa, e_ra);
            end
            sb_step();
            if (c == 0) mret_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        logic e_st, e_fl, e_rd;
        exc_req = 1'b1; exc_cause = 4'd2; irq = 1'b1; inst_pc = 32'h140;
        push_wr(MEPC, 32'h140); push_wr(MCAUSE, 32'h2); push_wr(MSTATUS, 32'h1880);
        exp_rd.push_back(32'h200);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e_st = (c <= 4); e_fl = (c == 0); e_rd = (c == 4);
            n_cmp++;
            if ({stall_o, flush_o, redirect_o} !== {e_st, e_fl, e_rd}) begin
                n_bad++;
                $display("FAIL simul_c%0d: got st/fl/rd=%b%b%b, required %b%b%b",
                         c, stall_o, flush_o, redirect_o, e_st, e_fl, e_rd);
            end
            sb_step();
            if (c == 0) exc_req = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (flush_o !== 1'b0) begin
                n_bad++;
                $display("FAIL irq_held_c%0d: got flush=%b, required 0", c, flush_o);
            end
            sb_step();
        end
        // mret re-enables MIE, so the still-high irq is taken on the first idle cycle after it.
        mret_req = 1'b1; inst_pc = 32'h144;
        push_wr(MSTATUS, 32'h1888);
        exp_rd.push_back(32'h140);
        push_wr(MEPC, 32'h144); push_wr(MCAUSE, 32'h8000000B); push_wr(MSTATUS, 32'h1880);
        exp_rd.push_back(32'h200);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e_st = 1'b1; e_fl = (c == 0) || (c == 4); e_rd = (c == 3);
            n_cmp++;
            if ({stall_o, flush_o, redirect_o} !== {e_st, e_fl, e_rd}) begin
                n_bad++;
                $display("FAIL mret_irq_c%0d: got st/fl/rd=%b%b%b, required %b%b%b",
                         c, stall_o, flush_o, redirect_o, e_st, e_fl, e_rd);
            end
            sb_step();
            if (c == 0) mret_req = 1'b0;
        end
        irq = 1'b0;
        repeat (5) begin
            @(negedge clk);
            sb_step();
        end
    endtask

    task automatic test_mtvec_align();
        csr_write(MTVEC, 32'h203);
        exc_req = 1'b1; exc_cause = 4'd3; inst_pc = 32'h1C0;
        push_wr(MEPC, 32'h1C0); push_wr(MCAUSE, 32'h3); push_wr(MSTATUS, 32'h1800);
        exp_rd.push_back(32'h200);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_cmp++;
                if (redirect_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mtvec_redirect: got redirect_o=%b, required 1", redirect_o);
                end
            end
            sb_step();
            if (c == 0) exc_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exc_req = 1'b1; exc_cause = 4'd11; inst_pc = 32'h1F0;
        push_wr(MEPC, 32'h1F0);
        @(negedge clk); sb_step();
        exc_req = 1'b0;
        @(negedge clk); sb_step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({stall_o, flush_o, redirect_o} !== 3'b000 || redirect_pc !== 32'h0 || csr_waddr_o !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_mid: got st/fl/rd=%b%b%b pc=%h wa=%h, required 000 pc=0 wa=000",
                     stall_o, flush_o, redirect_o, redirect_pc, csr_waddr_o);
        end
        repeat (2) begin
            @(negedge clk);
            sb_step();
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            sb_step();
        end
        n_cmp++;
        if (csr_mem[3] !== 32'h3 || csr_mem[0] !== 32'h1800 || csr_mem[2] !== 32'h1F0) begin
            n_bad++;
            $display("FAIL reset_abandon: got mcause=%h mstatus=%h mepc=%h, required 3/1800/1f0",
                     csr_mem[3], csr_mem[0], csr_mem[2]);
        end
        ex_csr_raddr = MEPC;
        @(negedge clk);
        n_cmp++;
        if (csr_raddr_o !== MEPC || csr_rdata_i !== 32'h1F0 || stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pass: got ra=%h rd=%h st=%b, required ra=%h rd=1f0 st=0",
                     csr_raddr_o, csr_rdata_i, stall_o, MEPC);
        end
        sb_step();
        ex_csr_raddr = '0;
        csr_write(MTVEC, 32'h300);
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_masked_irq();
        test_mret();
        test_simultaneous();
        test_mtvec_align();
        test_reset_mid();
        n_cmp++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d writes / %0d redirects outstanding, required 0/0",
                     exp_wr.size(), exp_rd.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
